led_pwm_regfile: RTL and testbench

//  Consumes byte-wide register writes (address/data/data_ready) from the SPI slave stage
//  and drives NUM_CH PWM LED outputs. Holds control, prescale and per-channel duty

---
 rtl/led_pwm_regfile_pkg.sv | 29 ++
 rtl/led_pwm_regfile_pwm_channel.sv | 51 +++++
 rtl/led_pwm_regfile.sv | 105 ++++++++++
 tb/tb_led_pwm_regfile.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_regfile_pkg.sv
// Shared definitions for the LED PWM register file: register addresses,
// CTRL bit positions, phase width and the fade step helper.
package led_pwm_regfile_pkg;

  localparam int unsigned PHASE_W = 8;

  localparam logic [7:0] ADDR_RSVD     = 8'h00;
  localparam logic [7:0] ADDR_CTRL     = 8'h01;
  localparam logic [7:0] ADDR_PRESCALE = 8'h02;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_INV  = 1;
  localparam int unsigned CTRL_FADE = 2;

  typedef logic [PHASE_W-1:0] phase_t;

  // One linear fade step of the active duty toward the target duty.
  function automatic phase_t fade_step(input phase_t active, input phase_t target);
    phase_t r;
    r = active;
    if (active < target) begin
      r = active + phase_t'(1);
    end else if (active > target) begin
      r = active - phase_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/led_pwm_regfile_pwm_channel.sv
// One PWM channel: target/active duty registers, period-aligned fade
// stepper, phase comparator and registered LED output.
module pwm_channel
  import led_pwm_regfile_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [7:0]   wr_data,
  input  logic         en,
  input  logic         inv,
  input  logic         fade,
  input  logic         period_start,
  input  phase_t       phase,
  output logic         led
);

  phase_t target_q;
  phase_t active_q;

  // Target duty as written over SPI.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_q <= '0;
    end else if (wr_en) begin
      target_q <= wr_data;
    end
  end

  // Active duty only moves on a period boundary, or tracks target while disabled.
  // A write landing on the boundary cycle is not seen here until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= '0;
    end else if (!en) begin
      active_q <= target_q;
    end else if (period_start) begin
      active_q <= fade ? fade_step(active_q, target_q) : target_q;
    end
  end

  // Registered comparator output with optional polarity inversion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led <= 1'b0;
    end else begin
      led <= (en & (phase < active_q)) ^ inv;
    end
  end

endmodule

// File: rtl/led_pwm_regfile.sv
// LED PWM register file: captures byte writes from the SPI slave on the
// rising edge of data_ready_in, holds CTRL/PRESCALE/duty registers and runs
// the shared prescaler and 8-bit phase counter for all channels.
module led_pwm_regfile
  import led_pwm_regfile_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter logic [7:0]  DUTY_BASE    = 8'h03,
  parameter logic [7:0]  PRESCALE_RST = 8'd0
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        address_in,
  input  logic [7:0]        data_in,
  input  logic              data_ready_in,
  output logic [NUM_CH-1:0] led_out,
  output logic              period_start,
  output logic              enabled
);

  logic       rdy_q;
  logic       wr_stb;
  logic [2:0] ctrl_q;
  logic [7:0] prescale_q;
  logic [7:0] pre_cnt_q;
  phase_t     phase_q;
  logic       en;
  logic       inv;
  logic       fade;
  logic       tick;

  // Previous data_ready level; resets high so a level held through reset never writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_q <= 1'b1;
    end else begin
      rdy_q <= data_ready_in;
    end
  end

  assign wr_stb = data_ready_in & ~rdy_q;

  // CTRL and PRESCALE register writes; reserved and unmapped addresses fall through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= '0;
      prescale_q <= PRESCALE_RST;
    end else if (wr_stb) begin
      if (address_in == ADDR_CTRL) begin
        ctrl_q <= data_in[2:0];
      end
      if (address_in == ADDR_PRESCALE) begin
        prescale_q <= data_in;
      end
    end
  end

  assign en           = ctrl_q[CTRL_EN];
  assign inv          = ctrl_q[CTRL_INV];
  assign fade         = ctrl_q[CTRL_FADE];
  assign enabled      = en;
  assign tick         = en & (pre_cnt_q == prescale_q);
  assign period_start = tick & (phase_q == '1);

  // Prescaler 0..PRESCALE; a count already past a newly lowered PRESCALE restarts at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt_q <= '0;
    end else if (!en || (pre_cnt_q >= prescale_q)) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_q + 8'd1;
    end
  end

  // Phase counter advances once per tick and wraps naturally at 255.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
    end else if (!en) begin
      phase_q <= '0;
    end else if (tick) begin
      phase_q <= phase_q + phase_t'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [7:0] CH_ADDR = 8'(DUTY_BASE + g);

    pwm_channel u_ch (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_stb && (address_in == CH_ADDR)),
      .wr_data      (data_in),
      .en           (en),
      .inv          (inv),
      .fade         (fade),
      .period_start (period_start),
      .phase        (phase_q),
      .led          (led_out[g])
    );
  end

endmodule

// File: tb/tb_led_pwm_regfile.sv
// Self-checking bench for led_pwm_regfile: directed scenarios plus random
// register traffic, compared every cycle against a behavioural model.
module tb_led_pwm_regfile;

  localparam int unsigned NUM_CH    = 3;
  localparam logic [7:0]  DUTY_BASE = 8'h03;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        address_in;
  logic [7:0]        data_in;
  logic              data_ready_in;
  logic [NUM_CH-1:0] led_out;
  logic              period_start;
  logic              enabled;

  led_pwm_regfile #(
    .NUM_CH       (NUM_CH),
    .DUTY_BASE    (DUTY_BASE),
    .PRESCALE_RST (8'd0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .address_in    (address_in),
    .data_in       (data_in),
    .data_ready_in (data_ready_in),
    .led_out       (led_out),
    .period_start  (period_start),
    .enabled       (enabled)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Behavioural model: register contents and timebase kept as plain integers.
  logic [2:0]        m_ctrl;
  int                m_pre;
  int                m_div;
  int                m_phase;
  bit                m_rdy;
  int                m_tgt [NUM_CH];
  int                m_act [NUM_CH];
  logic [NUM_CH-1:0] m_led;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_pre = 0; m_div = 0; m_phase = 0; m_rdy = 1'b1; m_led = '0;
    for (int n = 0; n < NUM_CH; n++) begin m_tgt[n] = 0; m_act[n] = 0; end
  endtask

  // Advance the model by one clock using the inputs present during that cycle.
  task automatic model_step(input logic dr, input logic [7:0] a, input logic [7:0] d);
    bit en, inv, fade, tick, pstart, stb;
    int ai;
    en     = m_ctrl[0];
    inv    = m_ctrl[1];
    fade   = m_ctrl[2];
    stb    = dr && !m_rdy;
    tick   = en && (m_div == m_pre);
    pstart = tick && (m_phase == 255);
    for (int n = 0; n < NUM_CH; n++) begin
      m_led[n] = (en && (m_phase < m_act[n])) ^ inv;
      if (!en) m_act[n] = m_tgt[n];
      else if (pstart) begin
        if (!fade) m_act[n] = m_tgt[n];
        else if (m_act[n] < m_tgt[n]) m_act[n] = m_act[n] + 1;
        else if (m_act[n] > m_tgt[n]) m_act[n] = m_act[n] - 1;
      end
    end
    m_div   = (en && m_div < m_pre) ? m_div + 1 : 0;
    m_phase = !en ? 0 : (tick ? (m_phase + 1) % 256 : m_phase);
    if (stb) begin
      ai = int'(a);
      if (ai == 1) m_ctrl = d[2:0];
      else if (ai == 2) m_pre = int'(d);
      else if (ai >= int'(DUTY_BASE) && ai < int'(DUTY_BASE) + NUM_CH)
        m_tgt[ai - int'(DUTY_BASE)] = int'(d);
    end
    m_rdy = dr;
  endtask

  // Drive inputs for one cycle, step model at the edge, compare just after.
  task automatic cyc(input logic dr, input logic [7:0] a, input logic [7:0] d);
    bit exp_ps;
    data_ready_in = dr; address_in = a; data_in = d;
    @(posedge clk);
    model_step(dr, a, d);
    #1;
    exp_ps = m_ctrl[0] && (m_div == m_pre) && (m_phase == 255);
    check("led_out", 32'(led_out), 32'(m_led));
    check("period_start", 32'(period_start), 32'(exp_ps));
    check("enabled", 32'(enabled), 32'(m_ctrl[0]));
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    cyc(1'b0, a, d);
    cyc(1'b1, a, d);
  endtask

  task automatic hold(input int unsigned n);
    for (int i = 0; i < int'(n); i++) cyc(1'b1, address_in, data_in);
  endtask

  task automatic wait_pstart(input int unsigned limit);
    int unsigned k;
    k = 0;
    while (period_start !== 1'b1 && k < limit) begin
      cyc(1'b1, address_in, data_in);
      k++;
    end
    if (period_start !== 1'b1) check("pstart_timeout", 32'd0, 32'd1);
  endtask

  task automatic count_high(input int unsigned ch, output int unsigned hits);
    hits = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1'b1, address_in, data_in);
      hits += 32'(led_out[ch]);
    end
  endtask

  initial begin
    int unsigned hits, sel, nlow, nhold, k;
    logic [7:0]  a, d;

    // Reset with data_ready high on the all-zero word: nothing is written.
    reset = 1'b0; data_ready_in = 1'b1; address_in = '0; data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_en", 32'(enabled), 32'd0);
    check("rst_ps", 32'(period_start), 32'd0);
    reset = 1'b1;
    hold(5);

    // Enable, prescale 0, duty0 = 0x40: 64 of 256 clocks high.
    write_reg(8'h01, 8'h01);
    write_reg(8'h02, 8'h00);
    write_reg(DUTY_BASE, 8'h40);
    wait_pstart(600);
    hold(1);
    count_high(0, hits);
    check("duty0_64", hits, 32'd64);

    // One write of duty1 then a held-high level with changing data: single write.
    write_reg(DUTY_BASE + 8'd1, 8'h80);
    for (int i = 0; i < 100; i++) cyc(1'b1, DUTY_BASE + 8'd1, 8'($urandom));
    wait_pstart(600);
    hold(1);
    count_high(1, hits);
    check("duty1_128", hits, 32'd128);

    // Duty write coincident with period_start (prescale 0 => next boundary 256 clks on).
    wait_pstart(600);
    hold(255);
    cyc(1'b0, DUTY_BASE, 8'h10);
    cyc(1'b1, DUTY_BASE, 8'h10);
    hold(600);

    // Fade: duty2 0 -> 3 in single steps, then back down to 1.
    write_reg(8'h01, 8'h05);
    write_reg(DUTY_BASE + 8'd2, 8'h03);
    hold(1300);
    write_reg(DUTY_BASE + 8'd2, 8'h01);
    hold(800);

    // Inverted with duty0 = 0: constant high; then disable.
    write_reg(8'h01, 8'h03);
    write_reg(DUTY_BASE, 8'h00);
    wait_pstart(600);
    hold(1);
    count_high(0, hits);
    check("inv_const", hits, 32'd256);
    write_reg(8'h01, 8'h00);
    hold(20);

    // Async reset mid-period with prescale 3 and phase near 0x7F.
    write_reg(8'h02, 8'h03);
    write_reg(8'h01, 8'h01);
    k = 0;
    while (m_phase != 127 && k < 2000) begin cyc(1'b1, address_in, data_in); k++; end
    check("phase_reach", 32'(m_phase), 32'd127);
    #2 reset = 1'b0;
    #1;
    check("async_led", 32'(led_out), 32'd0);
    check("async_en", 32'(enabled), 32'd0);
    check("async_ps", 32'(period_start), 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    hold(3);

    // Random register traffic including unmapped and reserved addresses.
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       a = 8'h00;
        1, 2:    a = 8'h01;
        3:       a = 8'h02;
        4, 5, 6: a = DUTY_BASE + 8'(sel - 4);
        7:       a = DUTY_BASE + 8'(NUM_CH);
        default: a = 8'($urandom);
      endcase
      d = 8'($urandom);
      if (a == 8'h01 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      if (a == 8'h02) d = 8'($urandom_range(0, 3));
      nlow = $urandom_range(1, 3);
      for (int i = 0; i < int'(nlow); i++) cyc(1'b0, a, d);
      cyc(1'b1, a, d);
      nhold = $urandom_range(1, 700);
      for (int i = 0; i < int'(nhold); i++) cyc(1'b1, 8'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
